key_encoder_8to3: RTL and testbench

Debounced 8-to-3 priority key encoder: the inverse of the board's 3-to-8 one-hot decoder. It takes eight raw push-button/switch lines, optionally synchronizes them, and debounces any press. It then emits the 3-bit binary index of the highest active key with a one-cycle valid strobe, and holds the code until the keys are released and stable. It sits between the board keys and the display/decoder logic, so that key index i drives decoder output bit i.

---
 rtl/key_enc_pkg.sv | 42 ++++
 rtl/key_sync.sv | 28 ++
 rtl/key_encoder_8to3.sv | 117 +++++++++++
 tb/tb_key_encoder_8to3.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/key_enc_pkg.sv
// Shared definitions for the debounced 8-to-3 key encoder:
// FSM state encoding, priority encoder and multi-key detector.
package key_enc_pkg;

   // Encoder FSM states, fixed 2-bit encoding
   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_DEB_PRESS   = 2'd1,
      ST_PRESSED     = 2'd2,
      ST_DEB_RELEASE = 2'd3
   } keyState_t;

   localparam int KEY_W  = 8;
   localparam int CODE_W = 3;

   // Index of the highest set key line; bit 7 has top priority.
   // An all-zero vector encodes to 0, which the FSM never accepts anyway.
   function automatic logic [CODE_W-1:0] priority_encode(input logic [KEY_W-1:0] keys);
      logic [CODE_W-1:0] idx;
      idx = '0;
      casez (keys)
         8'b1???????: idx = 3'd7;
         8'b01??????: idx = 3'd6;
         8'b001?????: idx = 3'd5;
         8'b0001????: idx = 3'd4;
         8'b00001???: idx = 3'd3;
         8'b000001??: idx = 3'd2;
         8'b0000001?: idx = 3'd1;
         default:     idx = 3'd0;
      endcase
      return idx;
   endfunction

   // True when more than one key line is set: clearing the lowest set
   // bit leaves something behind only if a second bit was present.
   function automatic logic multi_key(input logic [KEY_W-1:0] keys);
      logic [KEY_W-1:0] rest;
      rest = keys & (keys - KEY_W'(1));
      return (rest != '0);
   endfunction

endpackage

// File: rtl/key_sync.sv
// Parameterised-width two-flop synchronizer for asynchronous key lines.
// Each bit is synchronized independently; no multi-bit coherence is implied.
module key_sync #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // Two back-to-back flops give the first stage a full cycle to resolve
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/key_encoder_8to3.sv
// Debounced 8-to-3 priority key encoder.
// Accepts a key snapshot once it has been stable for DEBOUNCE_CYCLES
// samples, reports the highest key index with a one-cycle valid strobe,
// and holds the code until the keys have been released and stable.
// Optional feature macro: KEY_ENC_SYNC_EN adds a 2-flop synchronizer
// on every key line (two extra cycles of latency).
module key_encoder_8to3
   import key_enc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  key_in,
   output logic [2:0]  code,
   output logic        valid,
   output logic        held,
   output logic        multi
);

   // Counter only ever reaches DEBOUNCE_CYCLES-1, so clog2 bits suffice
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [KEY_W-1:0]  w_keyS;
   keyState_t         r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [KEY_W-1:0]  r_snap;
   logic [CODE_W-1:0] r_code;
   logic              r_valid;
   logic              r_held;
   logic              r_multi;

`ifdef KEY_ENC_SYNC_EN
   key_sync #(
      .WIDTH (KEY_W)
   ) u_keySync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (key_in),
      .o_sync  (w_keyS)
   );
`else
   assign w_keyS = key_in;
`endif

   // Debounce FSM: tracks the press snapshot, counts stable samples and
   // produces all registered outputs; valid defaults low every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_snap  <= '0;
         r_code  <= '0;
         r_valid <= 1'b0;
         r_held  <= 1'b0;
         r_multi <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_keyS != '0) begin
                  r_snap  <= w_keyS;
                  r_cnt   <= '0;
                  r_state <= ST_DEB_PRESS;
               end
            end
            ST_DEB_PRESS: begin
               if (w_keyS == '0) begin
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else if (w_keyS != r_snap) begin
                  r_snap <= w_keyS;
                  r_cnt  <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_code  <= priority_encode(r_snap);
                  r_multi <= multi_key(r_snap);
                  r_valid <= 1'b1;
                  r_held  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= ST_PRESSED;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_PRESSED: begin
               if (w_keyS == '0) begin
                  r_cnt   <= '0;
                  r_state <= ST_DEB_RELEASE;
               end
            end
            ST_DEB_RELEASE: begin
               if (w_keyS != '0) begin
                  r_cnt   <= '0;
                  r_state <= ST_PRESSED;
               end else if (r_cnt == CNT_LAST) begin
                  r_held  <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign code  = r_code;
   assign valid = r_valid;
   assign held  = r_held;
   assign multi = r_multi;

endmodule

// File: tb/tb_key_encoder_8to3.sv
// Self-checking bench for key_encoder_8to3 with DEBOUNCE_CYCLES=4.
// Reference model works on run lengths of the sampled key vector.
module tb_key_encoder_8to3;

   localparam int DEB = 4;
`ifdef KEY_ENC_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif

   logic       clk;
   logic       rst_n;
   logic [7:0] key_in;
   logic [2:0] code;
   logic       valid;
   logic       held;
   logic       multi;

   int errors;
   int checks;
   int cycleNo;
   int validEdge;
   int validCount;

   // Reference model state
   logic [7:0] hist [0:1];
   logic [7:0] mPrev;
   int         mRun;
   int         mZeroRun;
   logic       mHeld;
   logic       mValid;
   logic [2:0] mCode;
   logic       mMulti;

   key_encoder_8to3 #(
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_in (key_in),
      .code   (code),
      .valid  (valid),
      .held   (held),
      .multi  (multi)
   );

   // Free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] refIndex(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

   function automatic int refCount(input logic [7:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 8; i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, obs, expv, cycleNo, $time);
      end
   endtask

   task automatic modelReset();
      hist[0]  = '0;
      hist[1]  = '0;
      mPrev    = '0;
      mRun     = 0;
      mZeroRun = 0;
      mHeld    = 1'b0;
      mValid   = 1'b0;
      mCode    = '0;
      mMulti   = 1'b0;
   endtask

   // One rising edge of the model: a press is accepted when the same
   // nonzero vector has been seen on DEB+1 consecutive samples, a release
   // when zero has been seen on DEB+1 consecutive samples
   task automatic modelStep();
      logic [7:0] s;
      if (SYNC == 0) begin
         s = key_in;
      end else begin
         s = hist[(SYNC > 0) ? SYNC - 1 : 0];
         hist[1] = hist[0];
         hist[0] = key_in;
      end
      mValid = 1'b0;
      if (!mHeld) begin
         if (s != 0 && s == mPrev) mRun++;
         else mRun = (s != 0) ? 1 : 0;
         if (mRun == DEB + 1) begin
            mValid   = 1'b1;
            mHeld    = 1'b1;
            mCode    = refIndex(s);
            mMulti   = (refCount(s) > 1);
            mZeroRun = 0;
         end
      end else begin
         if (s == 0) mZeroRun++;
         else mZeroRun = 0;
         if (mZeroRun == DEB + 1) begin
            mHeld = 1'b0;
            mRun  = 0;
         end
      end
      mPrev = s;
   endtask

   task automatic checkAll();
      checkOutput("valid", 32'(valid), 32'(mValid));
      checkOutput("held",  32'(held),  32'(mHeld));
      checkOutput("code",  32'(code),  32'(mCode));
      checkOutput("multi", 32'(multi), 32'(mMulti));
   endtask

   // Drive key vector k for n cycles; called at a falling edge
   task automatic applyStimulus(input logic [7:0] k, input int n);
      for (int c = 0; c < n; c++) begin
         key_in = k;
         @(posedge clk);
         cycleNo++;
         if (rst_n) modelStep();
         else modelReset();
         @(negedge clk);
         if (valid === 1'b1) begin
            validCount++;
            if (validEdge < 0) validEdge = cycleNo;
         end
         checkAll();
      end
   endtask

   int vBefore;
   logic [7:0] rk;

   initial begin
      errors     = 0;
      checks     = 0;
      cycleNo    = 0;
      validEdge  = -1;
      validCount = 0;
      rst_n      = 1'b0;
      key_in     = 8'hFF;
      modelReset();
      @(negedge clk);

      // Reset held with all keys pressed
      applyStimulus(8'hFF, 5);

      // Single key from cycle 0
      rst_n     = 1'b1;
      cycleNo   = 0;
      validEdge = -1;
      applyStimulus(8'b0010_0000, 10);
      checkOutput("single_lat", 32'(validEdge), 32'(DEB + 1 + SYNC));
      applyStimulus(8'h00, DEB + SYNC + 3);

      // Multi key, then release bounce, then clean release
      applyStimulus(8'b1000_0001, 10);
      vBefore = validCount;
      applyStimulus(8'h00, 2);
      applyStimulus(8'b1000_0001, 4);
      checkOutput("rel_bounce_valids", 32'(validCount - vBefore), 32'd0);
      applyStimulus(8'h00, DEB + SYNC + 3);

      // Bounce on key 3, toggling every 2 cycles
      vBefore = validCount;
      for (int p = 0; p < 5; p++) begin
         applyStimulus(8'h08, 2);
         applyStimulus(8'h00, 2);
      end
      applyStimulus(8'h00, 6);
      checkOutput("bounce_valids", 32'(validCount - vBefore), 32'd0);

      // Reset asserted mid press-debounce
      applyStimulus(8'h04, 3);
      rst_n = 1'b0;
      modelReset();
      #1;
      checkAll();
      @(negedge clk);
      applyStimulus(8'h04, 2);
      rst_n     = 1'b1;
      cycleNo   = 0;
      validEdge = -1;
      applyStimulus(8'h04, 10);
      checkOutput("rst_lat", 32'(validEdge), 32'(DEB + 1 + SYNC));
      applyStimulus(8'h00, DEB + SYNC + 3);

      // Randomized key activity with glitches of varying length
      for (int r = 0; r < 300; r++) begin
         rk = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) rk = 8'h00;
         applyStimulus(rk, int'($urandom_range(1, 9)));
      end
      applyStimulus(8'h00, DEB + SYNC + 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
